fifo_pkt_framer: RTL

- Downstream consumer of sync_fifo. Drains the FIFO read port and emits fixed-length framed packets on a valid/ready stream.
- Frame format: SYNC byte, LEN byte, PKT_LEN payload bytes, then an 8-bit additive checksum.
- Prefetches FIFO data into a 2-entry skid buffer so frames stream at one beat per cycle with zero bubbles when the FIFO holds data and the sink is ready.

---
 rtl/fifo_pkt_framer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_pkt_framer.sv
// fifo_pkt_framer: drains a registered-read FIFO into framed packets.
// Frame = SYNC, LEN, PKT_LEN payload bytes, 8-bit additive checksum.
module fifo_pkt_framer #(
    parameter int         DATA_W  = 8,
    parameter int         PKT_LEN = 4,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rinc,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       frame_cnt
);
    typedef enum logic [2:0] {
        IDLE, HDR, LEN, PAY, CSUM
    } state_t;

    localparam logic [7:0] PLEN = 8'(PKT_LEN);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        reads_left;
    logic [7:0]        pay_left;
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [1:0]        cnt;
    logic              pending;
    logic              accept;
    logic              pop;
    logic              start;
    logic              rd_state;
    logic [2:0]        occ;

    assign accept   = m_valid && m_ready;
    assign pop      = accept && (state == PAY);
    assign busy     = (state != IDLE);
    assign rd_state = (state == HDR) || (state == LEN) || (state == PAY);
    assign start    = !fifo_empty &&
                      ((state == IDLE) || ((state == CSUM) && accept));

    // Occupancy after this cycle's pop, counting the byte still in flight.
    assign occ = {1'b0, cnt} + {2'b00, pending} - {2'b00, pop};

    assign fifo_rinc = rd_state && !fifo_empty &&
                       (reads_left != 8'd0) && (occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!fifo_empty) state_nx = HDR;
            HDR:  if (accept) state_nx = LEN;
            LEN:  if (accept) state_nx = PAY;
            PAY:  if (pop && (pay_left == 8'd1)) state_nx = CSUM;
            CSUM: if (accept) state_nx = fifo_empty ? IDLE : HDR;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        unique case (state)
            HDR: begin
                m_valid = 1'b1;
                m_data  = SYNC;
            end
            LEN: begin
                m_valid = 1'b1;
                m_data  = PLEN;
            end
            PAY: begin
                m_valid = (cnt != 2'd0);
                m_data  = buf0;
            end
            CSUM: begin
                m_valid = 1'b1;
                m_data  = csum;
                m_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reads_left <= '0;
            pay_left   <= '0;
            csum       <= '0;
            pending    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            pending <= fifo_rinc;
            if (start) begin
                reads_left <= PLEN;
                pay_left   <= PLEN;
                csum       <= '0;
            end else begin
                if (fifo_rinc) reads_left <= reads_left - 8'd1;
                if (pop) begin
                    pay_left <= pay_left - 8'd1;
                    csum     <= csum + buf0;
                end
            end
            if (accept && (state == CSUM)) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Two-entry skid buffer, buf0 is always the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
            cnt  <= '0;
        end else begin
            unique case ({pending, pop})
                2'b10: begin
                    if (cnt == 2'd0) buf0 <= fifo_rdata;
                    else             buf1 <= fifo_rdata;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
